// File: rtl/uart_fft_pkg.sv
// rtl/uart_fft_pkg.sv - shared types and constants for the UART I/Q receive path
package uart_fft_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 10;
    localparam int DW_DEFAULT           = 8;

    function automatic int half_bit(input int clks_per_bit);
        return clks_per_bit / 2;
    endfunction

    localparam int HALF_BIT = half_bit(CLKS_PER_BIT_DEFAULT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } rx_state_e;

    typedef struct packed {
        logic signed [DW_DEFAULT-1:0] re;
        logic signed [DW_DEFAULT-1:0] im;
    } cplx_t;

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART byte receiver with 2-flop line synchroniser
module uart_rx_byte
    import uart_fft_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int DW           = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_i,
    output logic          byte_valid_o,
    output logic [DW-1:0] byte_data_o,
    output logic          stop_ok_o
);

    localparam int HALF = half_bit(CLKS_PER_BIT);
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int BW   = $clog2(DW);
    localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DW - 1);

    logic [1:0]    sync_q;
    logic          rx_s;
    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [DW-1:0] sh_q, sh_d;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= 2'b11;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
        end else begin
            sync_q  <= {sync_q[0], rx_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!rx_s) state_d = ST_START;
            ST_START: if (cnt_q == HALF_END) state_d = rx_s ? ST_IDLE : ST_DATA;
            ST_DATA:  if (cnt_q == BIT_END && bit_q == LAST_BIT) state_d = ST_STOP;
            // Leave mid-stop-bit so a start bit right after a single stop bit is seen.
            ST_STOP:  if (cnt_q == BIT_END) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        bit_d = bit_q;
        sh_d  = sh_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
            end
            ST_START: if (cnt_q == HALF_END) cnt_d = '0;
            ST_DATA: begin
                if (cnt_q == BIT_END) begin
                    cnt_d = '0;
                    sh_d  = {rx_s, sh_q[DW-1:1]};
                    bit_d = bit_q + BW'(1);
                end
            end
            ST_STOP: ;
            default: cnt_d = '0;
        endcase
    end

    always_comb begin
        byte_valid_o = (state_q == ST_STOP) && (cnt_q == BIT_END);
        byte_data_o  = sh_q;
        stop_ok_o    = rx_s;
    end

endmodule

// File: rtl/uart_iq_rx_assembler.sv
// rtl/uart_iq_rx_assembler.sv - pairs UART bytes into I/Q samples with index; UART_FRAMING_CHECK_EN enables stop-bit checking
module uart_iq_rx_assembler
    import uart_fft_pkg::*;
#(
    parameter int N            = 256,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int DW           = DW_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_i,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_re,
    output logic signed [DW-1:0] out_im,
    output logic [$clog2(N)-1:0] out_idx,
    output logic                 out_last,
    output logic                 overrun,
    output logic                 frame_err
);

    localparam int IW = $clog2(N);

    logic          byte_valid, stop_ok, byte_ok;
    logic [DW-1:0] byte_data;

    logic          phase_q, phase_d;
    logic [DW-1:0] re_q, re_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          valid_q, valid_d;
    logic [DW-1:0] ore_q, ore_d, oim_q, oim_d;
    logic [IW-1:0] oidx_q, oidx_d;
    logic          ovr_q, ovr_d;
    logic          ferr_q, ferr_d;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT), .DW(DW)) u_rx (
        .clk          (clk),
        .rst          (rst),
        .rx_i         (rx_i),
        .byte_valid_o (byte_valid),
        .byte_data_o  (byte_data),
        .stop_ok_o    (stop_ok)
    );

`ifdef UART_FRAMING_CHECK_EN
    assign byte_ok = byte_valid && stop_ok;
`else
    logic unused_stop_ok;
    assign unused_stop_ok = stop_ok;
    assign byte_ok        = byte_valid;
`endif

    always_comb begin
        phase_d = phase_q;
        re_d    = re_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        ore_d   = ore_q;
        oim_d   = oim_q;
        oidx_d  = oidx_q;
        ovr_d   = ovr_q;
        ferr_d  = 1'b0;
        if (valid_q && out_ready) valid_d = 1'b0;
        if (byte_ok) begin
            if (!phase_q) begin
                re_d    = byte_data;
                phase_d = 1'b1;
            end else begin
                phase_d = 1'b0;
                idx_d   = idx_q + IW'(1);
                // The index advances even when the sample is dropped.
                if (!valid_q || out_ready) begin
                    valid_d = 1'b1;
                    ore_d   = re_q;
                    oim_d   = byte_data;
                    oidx_d  = idx_q;
                end else begin
                    ovr_d = 1'b1;
                end
            end
        end
`ifdef UART_FRAMING_CHECK_EN
        if (byte_valid && !stop_ok) begin
            ferr_d  = 1'b1;
            phase_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= 1'b0;
            re_q    <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            ore_q   <= '0;
            oim_q   <= '0;
            oidx_q  <= '0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            re_q    <= re_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            ore_q   <= ore_d;
            oim_q   <= oim_d;
            oidx_q  <= oidx_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign out_valid = valid_q;
    assign out_re    = ore_q;
    assign out_im    = oim_q;
    assign out_idx   = oidx_q;
    assign out_last  = (oidx_q == IW'(N - 1));
    assign overrun   = ovr_q;
`ifdef UART_FRAMING_CHECK_EN
    assign frame_err = ferr_q;
`else
    logic unused_ferr;
    assign unused_ferr = ferr_q;
    assign frame_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_iq_rx_assembler.sv
// tb/tb_uart_iq_rx_assembler.sv - directed self-checking bench for uart_iq_rx_assembler
module tb_uart_iq_rx_assembler;
    import uart_fft_pkg::*;

    localparam int N   = 4;
    localparam int CPB = 10;
    localparam int DW  = 8;
    localparam int IW  = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 rx_i = 1'b1;
    logic                 out_ready = 1'b0;
    logic                 out_valid;
    logic signed [DW-1:0] out_re, out_im;
    logic [IW-1:0]        out_idx;
    logic                 out_last, overrun, frame_err;

    typedef struct packed {
        cplx_t         s;
        logic [IW-1:0] idx;
        logic          last;
    } obs_t;

    obs_t mon_o;
    obs_t q[$];
    int   tests_run = 0;
    int   tests_failed = 0;
    int   fe_cnt = 0;

    uart_iq_rx_assembler #(.N(N), .CLKS_PER_BIT(CPB), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_i      (rx_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            mon_o.s.re = out_re;
            mon_o.s.im = out_im;
            mon_o.idx  = out_idx;
            mon_o.last = out_last;
            q.push_back(mon_o);
        end
        if (frame_err) fe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx_i = b;
        tick(CPB);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    task automatic send_pair(input logic [7:0] re, input logic [7:0] im);
        send_byte(re, 1'b1);
        send_byte(im, 1'b1);
    endtask

    task automatic expect_sample(input string tag, input int re, input int im, input int idx, input int last);
        obs_t o;
        check({tag, ".avail"}, 32'(q.size() > 0), 1);
        if (q.size() > 0) begin
            o = q.pop_front();
            check({tag, ".re"}, int'(o.s.re), re);
            check({tag, ".im"}, int'(o.s.im), im);
            check({tag, ".idx"}, 32'(o.idx), idx);
            check({tag, ".last"}, 32'(o.last), last);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx_i = 1'b1;
        tick(2);
        rst = 1'b0;
        q.delete();
        tick(2);
    endtask

    initial begin
        tick(1);
        check("rst.valid", 32'(out_valid), 0);
        check("rst.re", int'(out_re), 0);
        check("rst.im", int'(out_im), 0);
        check("rst.idx", 32'(out_idx), 0);
        check("rst.last", 32'(out_last), 0);
        check("rst.overrun", 32'(overrun), 0);
        check("rst.frame_err", 32'(frame_err), 0);
        rst = 1'b0;
        tick(3);

        // basic pair and latency bound around the imag stop bit
        out_ready = 1'b1;
        send_byte(8'h7F, 1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(1'b0);
        rx_i = 1'b1;
        tick(1);
        check("t1.early_valid", 32'(out_valid), 0);
        check("t1.early_q", q.size(), 0);
        tick(CPB - 1);
        expect_sample("t1", 127, 0, 0, 0);

        // back-to-back bytes, index wrap and out_last
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) send_byte(8'(i), 1'b1);
        expect_sample("t2.s0", 1, 2, 0, 0);
        expect_sample("t2.s1", 3, 4, 1, 0);
        expect_sample("t2.s2", 5, 6, 2, 0);
        expect_sample("t2.s3", 7, 8, 3, 1);
        expect_sample("t2.s4", 9, 10, 0, 0);
        check("t2.extra", q.size(), 0);

        // short low glitch is not a start bit
        rx_i = 1'b0;
        tick(3);
        rx_i = 1'b1;
        tick(30);
        check("t3.glitch_q", q.size(), 0);
        check("t3.glitch_valid", 32'(out_valid), 0);
        send_pair(8'h11, 8'h22);
        expect_sample("t3", 17, 34, 1, 0);

        // backpressure: second sample dropped, overrun sticky, index still advances
        do_reset();
        out_ready = 1'b0;
        send_pair(8'h10, 8'h20);
        check("t4.valid1", 32'(out_valid), 1);
        check("t4.ovr_before", 32'(overrun), 0);
        send_pair(8'h30, 8'h40);
        check("t4.valid2", 32'(out_valid), 1);
        check("t4.hold_re", int'(out_re), 16);
        check("t4.hold_im", int'(out_im), 32);
        check("t4.hold_idx", 32'(out_idx), 0);
        check("t4.overrun", 32'(overrun), 1);
        out_ready = 1'b1;
        tick(1);
        check("t4.drained", 32'(out_valid), 0);
        expect_sample("t4.s0", 16, 32, 0, 0);
        send_pair(8'h50, 8'h60);
        expect_sample("t4.s2", 80, 96, 2, 0);
        check("t4.ovr_sticky", 32'(overrun), 1);

        // bad stop bit
        do_reset();
        out_ready = 1'b1;
        fe_cnt = 0;
        send_byte(8'h55, 1'b0);
        rx_i = 1'b1;
        tick(30);
`ifdef UART_FRAMING_CHECK_EN
        check("t5.fe_pulses", fe_cnt, 1);
        check("t5.no_sample", q.size(), 0);
        send_pair(8'h80, 8'h7F);
        expect_sample("t5", -128, 127, 0, 0);
`else
        check("t5.fe_pulses", fe_cnt, 0);
        send_byte(8'h80, 1'b1);
        expect_sample("t5", 85, -128, 0, 0);
`endif

        // reset in the middle of an imag byte
        do_reset();
        out_ready = 1'b0;
        send_pair(8'h01, 8'h02);
        send_pair(8'h03, 8'h04);
        check("t6.ovr_pre", 32'(overrun), 1);
        send_byte(8'h05, 1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        rst = 1'b1;
        rx_i = 1'b1;
        #1;
        check("t6.valid", 32'(out_valid), 0);
        check("t6.re", int'(out_re), 0);
        check("t6.im", int'(out_im), 0);
        check("t6.idx", 32'(out_idx), 0);
        check("t6.overrun", 32'(overrun), 0);
        tick(2);
        rst = 1'b0;
        q.delete();
        out_ready = 1'b1;
        tick(20);
        send_pair(8'h0A, 8'h0B);
        expect_sample("t6", 10, 11, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
